// File: rtl/lfsr_pkg.sv
// Shared constants, state encoding and helpers for the 12-bit LFSR sequence checker.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 12;
  localparam int unsigned OFF_W  = 13;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned MC_W   = 4;

  localparam int unsigned TAP_A = 11;
  localparam int unsigned TAP_B = 5;
  localparam int unsigned TAP_C = 3;
  localparam int unsigned TAP_D = 0;

  localparam int unsigned OFFSET = 4096;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/lfsr_checker_step.sv
// Combinational successor of the 12-bit Fibonacci LFSR.
module lfsr_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] word,
  output logic [LFSR_W-1:0] succ
);

  assign succ = {word[LFSR_W-2:0], word[TAP_A] ^ word[TAP_B] ^ word[TAP_C] ^ word[TAP_D]};

endmodule

// File: rtl/lfsr_checker.sv
// Tracks a received 12-bit LFSR stream: hunts, verifies, locks, flywheels through errors
// and counts sequence, offset and word statistics.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_off,
  input  logic              clr,
  output logic              locked,
  output logic              err_pulse,
  output logic              off_err,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  off_err_count,
  output logic [CNT_W-1:0]  word_count
);

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] pred_q, pred_d;
  logic [LFSR_W-1:0] data_succ, pred_succ;
  logic [MC_W-1:0]   match_q, match_d, miss_q, miss_d;
  logic [MC_W-1:0]   match_inc, miss_inc;
  logic [OFF_W-1:0]  off_exp;
  logic              err_d, off_err_d;
  logic              err_inc, off_inc, word_inc;
  logic [CNT_W-1:0]  err_count_d, off_err_count_d, word_count_d;

  lfsr_step u_step_data (.word(in_data), .succ(data_succ));
  lfsr_step u_step_pred (.word(pred_q),  .succ(pred_succ));

  assign off_exp   = {1'b0, in_data} + OFF_W'(OFFSET);
  assign match_inc = match_q + MC_W'(1);
  assign miss_inc  = miss_q + MC_W'(1);

  // Next-state, pulse and counter-increment decode.
  always_comb begin
    state_d   = state_q;
    pred_d    = pred_q;
    match_d   = match_q;
    miss_d    = miss_q;
    err_d     = 1'b0;
    off_err_d = 1'b0;
    err_inc   = 1'b0;
    off_inc   = 1'b0;
    word_inc  = 1'b0;
    if (in_valid) begin
      off_err_d = (in_off != off_exp);
      off_inc   = off_err_d;
      case (state_q)
        HUNT: begin
          if (in_data != '0) begin
            pred_d  = data_succ;
            match_d = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (in_data == pred_q) begin
            pred_d  = data_succ;
            match_d = match_inc;
            if (match_inc == MC_W'(LOCK_CNT)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else if (in_data != '0) begin
            pred_d  = data_succ;
            match_d = '0;
          end else begin
            match_d = '0;
            state_d = HUNT;
          end
        end
        LOCKED: begin
          // Prediction free-runs so a single bad word does not disturb alignment.
          pred_d   = pred_succ;
          word_inc = 1'b1;
          if (in_data == pred_q) begin
            miss_d = '0;
          end else begin
            err_d   = 1'b1;
            err_inc = 1'b1;
            miss_d  = miss_inc;
            if (miss_inc == MC_W'(LOSS_CNT)) begin
              miss_d  = '0;
              state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    err_count_d     = clr ? '0 : (err_inc  ? sat_inc(err_count)     : err_count);
    off_err_count_d = clr ? '0 : (off_inc  ? sat_inc(off_err_count) : off_err_count);
    word_count_d    = clr ? '0 : (word_inc ? sat_inc(word_count)    : word_count);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= HUNT;
      pred_q        <= '0;
      match_q       <= '0;
      miss_q        <= '0;
      locked        <= 1'b0;
      err_pulse     <= 1'b0;
      off_err       <= 1'b0;
      err_count     <= '0;
      off_err_count <= '0;
      word_count    <= '0;
    end else begin
      state_q       <= state_d;
      pred_q        <= pred_d;
      match_q       <= match_d;
      miss_q        <= miss_d;
      locked        <= (state_d == LOCKED);
      err_pulse     <= err_d;
      off_err       <= off_err_d;
      err_count     <= err_count_d;
      off_err_count <= off_err_count_d;
      word_count    <= word_count_d;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a reference model predicts every registered output.
module tb_lfsr_checker;

  localparam int unsigned LOCK_N = 4;
  localparam int unsigned LOSS_N = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [11:0] in_data;
  logic [12:0] in_off;
  logic        clr;
  logic        locked, err_pulse, off_err;
  logic [15:0] err_count, off_err_count, word_count;

  lfsr_checker #(.LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_off(in_off),
    .clr(clr), .locked(locked), .err_pulse(err_pulse), .off_err(off_err),
    .err_count(err_count), .off_err_count(off_err_count), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        locked;
    logic        err_pulse;
    logic        off_err;
    logic [15:0] err_count;
    logic [15:0] off_err_count;
    logic [15:0] word_count;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b1;

  // Reference model state
  int          m_st;
  logic [11:0] m_pred;
  int          m_match, m_miss;
  logic [15:0] m_err, m_off, m_word;
  logic        m_ep, m_op;
  logic [11:0] gen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] succ(input logic [11:0] x);
    logic fb;
    fb = x[11] ^ x[5] ^ x[3] ^ x[0];
    return {x[10:0], fb};
  endfunction

  function automatic logic [12:0] good_off(input logic [11:0] d);
    return 13'(d) + 13'h1000;
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_pred = '0; m_match = 0; m_miss = 0;
    m_err = '0; m_off = '0; m_word = '0; m_ep = 1'b0; m_op = 1'b0;
  endtask

  task automatic model(input logic v, input logic [11:0] d, input logic [12:0] o, input logic c);
    m_ep = 1'b0;
    m_op = 1'b0;
    if (v) begin
      if (o != good_off(d)) begin
        m_op  = 1'b1;
        m_off = sat(m_off);
      end
      if (m_st == 0) begin
        if (d != 12'h000) begin m_pred = succ(d); m_match = 0; m_st = 1; end
      end else if (m_st == 1) begin
        if (d == m_pred) begin
          m_pred = succ(d);
          m_match++;
          if (m_match == LOCK_N) begin m_st = 2; m_miss = 0; end
        end else if (d != 12'h000) begin
          m_pred = succ(d); m_match = 0;
        end else begin
          m_st = 0; m_match = 0;
        end
      end else begin
        m_word = sat(m_word);
        if (d == m_pred) m_miss = 0;
        else begin
          m_ep  = 1'b1;
          m_err = sat(m_err);
          m_miss++;
          if (m_miss == LOSS_N) begin m_st = 0; m_miss = 0; end
        end
        m_pred = succ(m_pred);
      end
    end
    if (c) begin m_err = '0; m_off = '0; m_word = '0; end
  endtask

  task automatic step(input logic v, input logic [11:0] d, input logic [12:0] o, input logic c);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_data = d; in_off = o; clr = c;
    model(v, d, o, c);
    e = '{locked: (m_st == 2), err_pulse: m_ep, off_err: m_op,
          err_count: m_err, off_err_count: m_off, word_count: m_word};
    if (chk_en) sb_q.push_back(e);
  endtask

  task automatic send_good();
    gen = succ(gen);
    step(1'b1, gen, good_off(gen), 1'b0);
  endtask

  task automatic send_wrong(input logic c);
    logic [11:0] w;
    gen = succ(gen);
    w = gen ^ 12'h800;
    step(1'b1, w, good_off(w), c);
  endtask

  task automatic relock(input logic [11:0] seed, input logic [12:0] seed_off);
    gen = seed;
    step(1'b1, seed, seed_off, 1'b0);
    for (int i = 0; i < int'(LOCK_N); i++) send_good();
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Compare each registered result one step after the edge that produced it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("locked",        32'(locked),        32'(e.locked));
      check("err_pulse",     32'(err_pulse),     32'(e.err_pulse));
      check("off_err",       32'(off_err),       32'(e.off_err));
      check("err_count",     32'(err_count),     32'(e.err_count));
      check("off_err_count", 32'(off_err_count), 32'(e.off_err_count));
      check("word_count",    32'(word_count),    32'(e.word_count));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_err, k;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_off = '0; clr = 1'b0;
    model_reset();
    #3;
    check("rst_locked",    32'(locked),        32'd0);
    check("rst_err_count", 32'(err_count),     32'd0);
    check("rst_word",      32'(word_count),    32'd0);
    check("rst_off_count", 32'(off_err_count), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Zero word in HUNT is ignored, then lock on 001..01E.
    step(1'b0, 12'h000, 13'h0000, 1'b0);
    step(1'b1, 12'h000, good_off(12'h000), 1'b0);
    relock(12'h001, good_off(12'h001));
    settle();
    check("lock_locked", 32'(locked),     32'd1);
    check("lock_err",    32'(err_count),  32'd0);
    check("lock_words",  32'(word_count), 32'd0);

    // Single error is flywheeled through.
    send_good();
    send_wrong(1'b0);
    send_good();
    send_good();
    step(1'b0, 12'hABC, 13'h0000, 1'b0);
    settle();
    check("single_err",    32'(err_count), 32'd1);
    check("single_locked", 32'(locked),    32'd1);

    // Loss of lock after LOSS_N misses, one of them a zero word.
    gen = succ(gen);
    step(1'b1, 12'h000, good_off(12'h000), 1'b0);
    for (int i = 1; i < int'(LOSS_N) - 1; i++) send_wrong(1'b0);
    settle();
    check("loss_pre_locked", 32'(locked), 32'd1);
    send_wrong(1'b0);
    settle();
    check("loss_locked", 32'(locked),    32'd0);
    check("loss_err",    32'(err_count), 32'(1 + LOSS_N));

    // Relock with a bad offset on the seed word.
    relock(12'h001, 13'h1002);
    settle();
    check("relock_locked", 32'(locked),        32'd1);
    check("offset_count",  32'(off_err_count), 32'd1);

    // clr beats a same-cycle error, then build err_count to 7.
    send_wrong(1'b1);
    settle();
    check("clr_err", 32'(err_count), 32'd0);
    for (int i = 0; i < 7; i++) send_wrong(1'b0);
    settle();
    check("pre_rst_err", 32'(err_count), 32'd7);

    // Asynchronous reset mid-cycle while locked.
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("async_locked", 32'(locked),    32'd0);
    check("async_err",    32'(err_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Saturation: runs of LOSS_N-1 errors kept alive by one good word.
    relock(12'h5A5, good_off(12'h5A5));
    chk_en = 1'b0;
    n_err = 0;
    k = 0;
    while (n_err < 65540) begin
      if (k < int'(LOSS_N) - 1) begin
        send_wrong(1'b0); n_err++; k++;
      end else begin
        send_good(); k = 0;
      end
    end
    chk_en = 1'b1;
    send_good();
    settle();
    check("sat_err",  32'(err_count),  32'hFFFF);
    check("sat_word", 32'(word_count), 32'hFFFF);
    send_wrong(1'b1);
    settle();
    check("sat_clr_err", 32'(err_count), 32'd0);
    check("sat_clr_pulse", 32'(err_pulse), 32'd1);
    step(1'b0, 12'h000, 13'h0000, 1'b0);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
